// File: rtl/alu_result_buffer.sv
// Writeback-side result buffer behind the ALU. It re-aligns the early valid/address
// with late ALU data, queues results in a small FIFO and drains them over valid/ready.
`timescale 1ns/1ps
module alu_result_buffer #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 6,
  parameter int DEPTH       = 4,
  parameter int ALU_LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid_i,
  input  logic [ADDR_WIDTH-1:0]    alu_addr_i,
  input  logic [DATA_WIDTH-1:0]    alu_data_i,
  input  logic                     alu_cout_i,
  output logic                     stall_o,
  output logic                     wb_valid_o,
  input  logic                     wb_ready_i,
  output logic [ADDR_WIDTH-1:0]    wb_addr_o,
  output logic [DATA_WIDTH-1:0]    wb_data_o,
  output logic                     wb_cout_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o
);

  localparam int PW = $clog2(DEPTH) + 1;  // pointer width incl. wrap bit
  localparam int IW = PW - 1;             // storage index width
  localparam int SW = PW + 2;             // headroom for count + in-flight sum
  localparam logic [SW-1:0] STALL_LEVEL = SW'(DEPTH - 1);

  logic                  tap_valid;
  logic [ADDR_WIDTH-1:0] tap_addr;
  logic [SW-1:0]         in_flight;

  // Alignment delay line: the address travels alongside the ALU pipeline so it
  // meets its data at the tap. It shifts every cycle; there is no enable.
  generate
    if (ALU_LATENCY == 0) begin : g_comb_alu
      assign tap_valid = alu_valid_i;
      assign tap_addr  = alu_addr_i;
      assign in_flight = '0;
    end else begin : g_piped_alu
      logic [ALU_LATENCY-1:0] dl_valid;
      logic [ADDR_WIDTH-1:0]  dl_addr [ALU_LATENCY];

      always_ff @(posedge clk) begin
        if (reset) begin
          dl_valid <= '0;
          for (int i = 0; i < ALU_LATENCY; i++) dl_addr[i] <= '0;
        end else begin
          dl_valid[0] <= alu_valid_i;
          dl_addr[0]  <= alu_addr_i;
          for (int i = 1; i < ALU_LATENCY; i++) begin
            dl_valid[i] <= dl_valid[i-1];
            dl_addr[i]  <= dl_addr[i-1];
          end
        end
      end

      always_comb begin
        in_flight = '0;
        for (int i = 0; i < ALU_LATENCY; i++) in_flight = in_flight + SW'(dl_valid[i]);
      end

      assign tap_valid = dl_valid[ALU_LATENCY-1];
      assign tap_addr  = dl_addr[ALU_LATENCY-1];
    end
  endgenerate

  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         count_q;
  logic                  overflow_q;
  logic [ADDR_WIDTH-1:0] mem_addr [DEPTH];
  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic [DEPTH-1:0]      mem_cout;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic [SW-1:0]         occupancy;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);

  // Handshake: a transfer happens on every cycle where wb_valid_o and wb_ready_i
  // are both high; while wb_valid_o is high and wb_ready_i low the head is held.
  assign pop  = wb_valid_o & wb_ready_i;
  assign push = tap_valid & (~full | pop);

  // Payload storage carries no reset; empty-forcing keeps outputs clean.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr[IW-1:0]] <= tap_addr;
      mem_data[wr_ptr[IW-1:0]] <= alu_data_i;
      mem_cout[wr_ptr[IW-1:0]] <= alu_cout_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + PW'(1);
        2'b01:   count_q <= count_q - PW'(1);
        default: count_q <= count_q;
      endcase
      // A result reaching a full buffer with no pop is lost; flag it until reset.
      if (tap_valid && full && !pop) overflow_q <= 1'b1;
    end
  end

  assign wb_valid_o = (count_q != '0);
  assign wb_addr_o  = empty ? '0 : mem_addr[rd_ptr[IW-1:0]];
  assign wb_data_o  = empty ? '0 : mem_data[rd_ptr[IW-1:0]];
  assign wb_cout_o  = empty ? 1'b0 : mem_cout[rd_ptr[IW-1:0]];
  assign count_o    = count_q;
  assign overflow_o = overflow_q;

  // Counting in-flight results reserves a slot for everything already issued,
  // so an op issued while stall_o is low always finds room.
  assign occupancy = SW'(count_q) + in_flight;
  assign stall_o   = (occupancy >= STALL_LEVEL);

endmodule

// File: tb/tb_alu_result_buffer.sv
// Bench for alu_result_buffer: three instances (ALU latency 0, 1, 2) share one
// issue stream; a negedge monitor pops an expected queue per instance.
`timescale 1ns/1ps
module tb_alu_result_buffer;
  localparam int DW = 16;
  localparam int AW = 6;
  localparam int DEPTH = 4;
  localparam int CW = 3;
  localparam int W = AW + DW + 1;

  int errors = 0;
  int checks = 0;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          op_valid = 1'b0;
  logic [AW-1:0] op_addr = '0;
  logic [DW-1:0] op_data = '0;
  logic          op_cout = 1'b0;
  logic [2:0]    ready = 3'b000;

  // Late data for the piped instances, delayed like a real ALU pipeline.
  logic [DW-1:0] data_d1 = '0, data_d2 = '0;
  logic          cout_d1 = 1'b0, cout_d2 = 1'b0;
  always @(posedge clk) begin
    data_d1 <= op_data;
    data_d2 <= data_d1;
    cout_d1 <= op_cout;
    cout_d2 <= cout_d1;
  end

  logic [DW-1:0] data_in [3];
  logic          cout_in [3];
  assign data_in[0] = op_data;
  assign data_in[1] = data_d1;
  assign data_in[2] = data_d2;
  assign cout_in[0] = op_cout;
  assign cout_in[1] = cout_d1;
  assign cout_in[2] = cout_d2;

  logic          stall [3];
  logic          wb_valid [3];
  logic [AW-1:0] wb_addr [3];
  logic [DW-1:0] wb_data [3];
  logic          wb_cout [3];
  logic [CW-1:0] count [3];
  logic          overflow [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    alu_result_buffer #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .ALU_LATENCY(g)
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .alu_valid_i(op_valid),
      .alu_addr_i (op_addr),
      .alu_data_i (data_in[g]),
      .alu_cout_i (cout_in[g]),
      .stall_o    (stall[g]),
      .wb_valid_o (wb_valid[g]),
      .wb_ready_i (ready[g]),
      .wb_addr_o  (wb_addr[g]),
      .wb_data_o  (wb_data[g]),
      .wb_cout_o  (wb_cout[g]),
      .count_o    (count[g]),
      .overflow_o (overflow[g])
    );
  end

  // scoreboard
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  logic [W-1:0] exp_q2[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pop_check(input int g, input logic [W-1:0] act);
    logic [W-1:0] exp;
    int n;
    case (g)
      0:       n = exp_q0.size();
      1:       n = exp_q1.size();
      default: n = exp_q2.size();
    endcase
    checks++;
    if (n == 0) begin
      errors++;
      $display("FAIL wb_unexpected[lat%0d]: got %0h expected no transfer", g, act);
    end else begin
      case (g)
        0:       exp = exp_q0.pop_front();
        1:       exp = exp_q1.pop_front();
        default: exp = exp_q2.pop_front();
      endcase
      if (act !== exp) begin
        errors++;
        $display("FAIL wb_payload[lat%0d]: got %0h expected %0h", g, act, exp);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      for (int g = 0; g < 3; g++)
        if (wb_valid[g] && ready[g]) pop_check(g, {wb_addr[g], wb_data[g], wb_cout[g]});
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    op_valid = 1'b0;
  endtask

  task automatic issue(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic c,
                       input bit expect_it);
    op_valid = 1'b1;
    op_addr  = a;
    op_data  = d;
    op_cout  = c;
    if (expect_it) begin
      exp_q0.push_back({a, d, c});
      exp_q1.push_back({a, d, c});
      exp_q2.push_back({a, d, c});
    end
  endtask

  task automatic apply_reset();
    tick();
    reset = 1'b1;
    ready = 3'b000;
    exp_q0.delete();
    exp_q1.delete();
    exp_q2.delete();
    tick();
    reset = 1'b0;
  endtask

  task automatic fill(input logic [7:0] base);
    for (int i = 0; i < 4; i++) begin
      tick();
      issue(AW'(base[5:0] + 6'(i)), DW'(base + 8'(i)), i[0], 1'b1);
    end
    tick();
    tick();
    tick();
  endtask

  task automatic drain(input string name);
    bit done = 1'b0;
    ready = 3'b111;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      done = (count[0] == 0) && (count[1] == 0) && (count[2] == 0) &&
             (exp_q0.size() == 0) && (exp_q1.size() == 0) && (exp_q2.size() == 0);
    end
    check(name, 32'(done), 32'd1);
    ready = 3'b000;
  endtask

  task automatic check_idle(input string name);
    for (int g = 0; g < 3; g++) begin
      check($sformatf("%s_valid[lat%0d]", name, g), 32'(wb_valid[g]), 0);
      check($sformatf("%s_count[lat%0d]", name, g), 32'(count[g]), 0);
      check($sformatf("%s_stall[lat%0d]", name, g), 32'(stall[g]), 0);
      check($sformatf("%s_ovf[lat%0d]", name, g), 32'(overflow[g]), 0);
      check($sformatf("%s_head[lat%0d]", name, g), 32'({wb_addr[g], wb_data[g], wb_cout[g]}), 0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    apply_reset();
    @(negedge clk);
    check_idle("reset");

    // T1: single result through the latency-1 instance
    ready = 3'b111;
    tick();
    issue(6'd5, 16'hBEEF, 1'b1, 1'b1);
    tick();
    tick();
    @(negedge clk);
    check("t1_valid_c2", 32'(wb_valid[1]), 1);
    check("t1_addr_c2", 32'(wb_addr[1]), 5);
    check("t1_data_c2", 32'(wb_data[1]), 32'hBEEF);
    check("t1_cout_c2", 32'(wb_cout[1]), 1);
    tick();
    @(negedge clk);
    check("t1_valid_c3", 32'(wb_valid[1]), 0);
    check("t1_count_c3", 32'(count[1]), 0);
    drain("t1_drain");

    // T2: fill to DEPTH with ready low, watch stall, then drain in order
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      issue(AW'(i + 1), DW'(8'h11 * (i + 1)), i[0], 1'b1);
      if (i == 2) begin
        @(negedge clk);
        check("t2_stall_cnt1_inflt1", 32'(stall[1]), 0);
      end
      if (i == 3) begin
        @(negedge clk);
        check("t2_stall_cnt2_inflt1", 32'(stall[1]), 1);
      end
    end
    tick();
    tick();
    @(negedge clk);
    check("t2_count_full", 32'(count[1]), 4);
    check("t2_stall_full", 32'(stall[1]), 1);
    check("t2_valid_full", 32'(wb_valid[1]), 1);
    check("t2_head_full", 32'(wb_data[1]), 32'h11);
    tick();
    @(negedge clk);
    check("t2_count_lat0", 32'(count[0]), 4);
    check("t2_count_lat2", 32'(count[2]), 4);
    drain("t2_drain");

    // T3: forced push into a full buffer is dropped and flagged
    fill(8'h31);
    @(negedge clk);
    for (int g = 0; g < 3; g++) check($sformatf("t3_full[lat%0d]", g), 32'(count[g]), 4);
    tick();
    issue(6'h3F, 16'h0055, 1'b1, 1'b0);
    tick();
    @(negedge clk);
    check("t3_ovf_aligned_cycle", 32'(overflow[1]), 0);
    tick();
    @(negedge clk);
    check("t3_ovf_next_cycle", 32'(overflow[1]), 1);
    check("t3_count_held", 32'(count[1]), 4);
    tick();
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check($sformatf("t3_ovf[lat%0d]", g), 32'(overflow[g]), 1);
      check($sformatf("t3_count[lat%0d]", g), 32'(count[g]), 4);
    end
    drain("t3_drain");
    @(negedge clk);
    check("t3_ovf_sticky", 32'(overflow[1]), 1);
    apply_reset();
    @(negedge clk);
    for (int g = 0; g < 3; g++) check($sformatf("t3_ovf_cleared[lat%0d]", g), 32'(overflow[g]), 0);

    // T4: full with a pop in the aligned cycle accepts the push
    fill(8'h61);
    tick();
    issue(6'h25, 16'h0065, 1'b1, 1'b1);
    ready = 3'b001;
    tick();
    ready = 3'b010;
    @(negedge clk);
    check("t4_count_before", 32'(count[1]), 4);
    tick();
    ready = 3'b100;
    @(negedge clk);
    check("t4_count_after", 32'(count[1]), 4);
    check("t4_head_advanced", 32'(wb_data[1]), 32'h62);
    tick();
    ready = 3'b000;
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check($sformatf("t4_count[lat%0d]", g), 32'(count[g]), 4);
      check($sformatf("t4_ovf[lat%0d]", g), 32'(overflow[g]), 0);
      check($sformatf("t4_head[lat%0d]", g), 32'(wb_data[g]), 32'h62);
    end
    drain("t4_drain");

    // T5: reset with 3 queued and 1 in flight discards everything
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      issue(AW'(i + 8), DW'(16'hA000 + i), 1'b0, 1'b0);
    end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check_idle("t5");
    ready = 3'b111;
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      check($sformatf("t5_no_ghost_c%0d", i), 32'({wb_valid[2], wb_valid[1], wb_valid[0]}), 0);
    end
    ready = 3'b000;

    // T6: random issue obeying stall, random per-instance ready
    for (int i = 0; i < 2000; i++) begin
      tick();
      ready = 3'($urandom_range(0, 7));
      if (!(stall[0] || stall[1] || stall[2]) && $urandom_range(0, 3) != 0)
        issue(AW'($urandom_range(0, 63)), DW'($urandom_range(0, 65535)),
              1'($urandom_range(0, 1)), 1'b1);
    end
    drain("t6_drain");
    @(negedge clk);
    for (int g = 0; g < 3; g++) check($sformatf("t6_no_ovf[lat%0d]", g), 32'(overflow[g]), 0);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
